// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: phase sequencer that reloads the countdown timer and drives the lamps
module traffic_light_ctrl #(
  parameter int FLASH_HALF = 5,
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flash_req,
  input  logic [TW-1:0] timer,
  output logic          load,
  output logic [1:0]    current_state,
  output logic          lamp_g,
  output logic          lamp_y,
  output logic          lamp_r,
  output logic          phase_done
);
  localparam int FW = $clog2(FLASH_HALF + 1);
  typedef enum logic [1:0] {GREEN, YELLOW, RED, FLASH} color_t;
  typedef enum logic [1:0] {LOAD, ARM, COUNT} phase_t;
  color_t color, color_n;
  phase_t phase, phase_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic load_n, done_n, blink_n, wrap;
  assign wrap = fcnt == FW'(FLASH_HALF - 1);
  assign current_state = color;
  always_comb begin
    color_n = color;
    phase_n = phase;
    fcnt_n = '0;
    load_n = 1'b0;
    done_n = 1'b0;
    blink_n = 1'b1;
    if (flash_req) begin
      color_n = FLASH;
      fcnt_n = (color != FLASH || wrap) ? '0 : fcnt + 1'b1;
      blink_n = (color != FLASH) ? 1'b1 : lamp_y ^ wrap;
    end else if (color == FLASH) begin
      color_n = RED;
      phase_n = LOAD;
    end else if (en) begin
      if (phase == LOAD) begin
        load_n = 1'b1;
        phase_n = ARM;
      end else if (phase == ARM) begin
        // the timer may still show a stale zero until the reload lands
        phase_n = COUNT;
      end else if (timer == '0) begin
        color_n = (color == GREEN) ? YELLOW : (color == YELLOW) ? RED : GREEN;
        load_n = 1'b1;
        done_n = 1'b1;
        phase_n = ARM;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color <= GREEN;
      phase <= LOAD;
      fcnt <= '0;
      load <= 1'b0;
      phase_done <= 1'b0;
      lamp_g <= 1'b1;
      lamp_y <= 1'b0;
      lamp_r <= 1'b0;
    end else begin
      color <= color_n;
      phase <= phase_n;
      fcnt <= fcnt_n;
      load <= load_n;
      phase_done <= done_n;
      lamp_g <= color_n == GREEN;
      lamp_y <= (color_n == FLASH) ? blink_n : color_n == YELLOW;
      lamp_r <= color_n == RED;
    end
  end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: vector table, directed scenarios and random run against a behavioural model
module tb_traffic_light_ctrl;
  localparam int FH = 5;
  logic clk = 0, rst_n = 0, en = 0, flash_req = 0;
  logic [31:0] timer = 0;
  logic load, lamp_g, lamp_y, lamp_r, phase_done;
  logic [1:0] current_state;
  int n_cmp = 0, n_bad = 0;
  int unsigned tm = 0;
  bit ovr = 0;
  logic [31:0] ovr_val = 0;
  int m_col = 0, m_wait = 2, m_age = 0;
  bit m_load = 0, m_done = 0;
  int nl;
  logic [19:0] yseq;
  typedef struct {
    logic en;
    logic fr;
    logic [31:0] t;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[15];

  traffic_light_ctrl #(.FLASH_HALF(FH), .TW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flash_req(flash_req), .timer(timer),
    .load(load), .current_state(current_state), .lamp_g(lamp_g), .lamp_y(lamp_y),
    .lamp_r(lamp_r), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_out();
    return {current_state, load, phase_done, lamp_g, lamp_y, lamp_r};
  endfunction

  // colour index: 0 green, 1 yellow, 2 red, 3 flashing; m_wait = en-cycles before the timer is watched
  function automatic logic [6:0] model_out();
    logic [1:0] s;
    s = 2'(m_col);
    return {s, m_load, m_done, m_col == 0, m_col == 1 || (m_col == 3 && (m_age / FH) % 2 == 0), m_col == 2};
  endfunction

  function automatic int unsigned dur(int c);
    return c == 0 ? 15 : c == 1 ? 3 : c == 2 ? 18 : 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_wait = 2; m_age = 0; m_load = 0; m_done = 0; tm = 0;
  endtask

  task automatic model_step(logic [31:0] t);
    m_load = 0;
    m_done = 0;
    if (flash_req) begin
      m_age = (m_col == 3) ? m_age + 1 : 0;
      m_col = 3;
    end else if (m_col == 3) begin
      m_col = 2;
      m_wait = 2;
    end else if (en) begin
      if (m_wait > 0) begin
        m_load = (m_wait == 2);
        m_wait--;
      end else if (t == 0) begin
        m_col = (m_col + 1) % 3;
        m_load = 1;
        m_done = 1;
        m_wait = 1;
      end
    end
  endtask

  task automatic tick(string name = "step");
    logic [31:0] t;
    int unsigned tn;
    t = ovr ? ovr_val : 32'(tm);
    timer = t;
    tn = m_load ? dur(m_col) : (tm != 0 ? tm - 1 : 0);
    if (!rst_n) begin
      model_reset();
      tn = 0;
    end else model_step(t);
    @(posedge clk);
    #1;
    tm = tn;
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic wait_load(string name, int exp);
    int n;
    n = 0;
    do begin
      tick(name);
      n++;
    end while (load !== 1'b1 && n < 100);
    check({name, "_gap"}, n, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd0, 7'b0000100};
    vecs[1]  = '{1'b1, 1'b0, 32'd0, 7'b0010100};
    vecs[2]  = '{1'b1, 1'b0, 32'd0, 7'b0000100};
    vecs[3]  = '{1'b1, 1'b0, 32'd5, 7'b0000100};
    vecs[4]  = '{1'b1, 1'b0, 32'd0, 7'b0111010};
    vecs[5]  = '{1'b1, 1'b0, 32'd0, 7'b0100010};
    vecs[6]  = '{1'b0, 1'b0, 32'd0, 7'b0100010};
    vecs[7]  = '{1'b1, 1'b0, 32'd0, 7'b1011001};
    vecs[8]  = '{1'b1, 1'b1, 32'd0, 7'b1100010};
    vecs[9]  = '{1'b0, 1'b1, 32'd0, 7'b1100010};
    vecs[10] = '{1'b1, 1'b0, 32'd7, 7'b1000001};
    vecs[11] = '{1'b1, 1'b0, 32'd7, 7'b1010001};
    vecs[12] = '{1'b1, 1'b0, 32'd0, 7'b1000001};
    vecs[13] = '{1'b1, 1'b0, 32'd0, 7'b0011100};
    vecs[14] = '{1'b1, 1'b0, 32'd0, 7'b0000100};
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(dut_out()), 32'(7'b0000100));
    rst_n = 1;
    foreach (vecs[i]) begin
      en = vecs[i].en;
      flash_req = vecs[i].fr;
      timer = vecs[i].t;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end
    // normal cycle from reset
    en = 0; flash_req = 0; rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    en = 1; rst_n = 1;
    wait_load("s1_first", 1);
    wait_load("s1_g2y", 17);
    wait_load("s1_y2r", 5);
    wait_load("s1_r2g", 20);
    // night flash in the middle of red
    wait_load("s4_g", 17);
    wait_load("s4_y", 5);
    repeat (6) tick();
    flash_req = 1;
    yseq = '0;
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      tick("s4_flash");
      yseq = {yseq[18:0], lamp_y};
      nl += int'(load);
    end
    check("s4_blink", 32'(yseq), 32'(20'b11111000001111100000));
    check("s4_noload", nl, 0);
    flash_req = 0;
    tick("s4_exit");
    check("s4_red", 32'({current_state, lamp_r, load}), 32'(4'b1010));
    wait_load("s4_reload", 1);
    wait_load("s4_red_len", 20);
    // flash arriving together with expiry
    repeat (3) tick();
    nl = 0;
    while (tm != 0 && nl < 100) begin
      tick();
      nl++;
    end
    flash_req = 1;
    tick("s5");
    check("s5_flash_wins", 32'({current_state, load, phase_done}), 32'(4'b1100));
    flash_req = 0;
    tick();
    wait_load("s5_reload", 1);
    wait_load("s2_pre", 20);
    // pause through expiry
    repeat (8) tick();
    en = 0;
    nl = 0;
    for (int i = 0; i < 10; i++) begin
      tick("s2_pause");
      nl += int'(load);
    end
    check("s2_noload", nl, 0);
    check("s2_green_held", 32'(current_state), 0);
    en = 1;
    tick("s2_resume");
    check("s2_yellow", 32'({current_state, load, phase_done, lamp_y}), 32'(5'b01111));
    tick();
    check("s2_done_pulse", 32'(phase_done), 0);
    // pause exactly on the load cycle
    en = 0; rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    nl = 0;
    repeat (3) begin
      tick("s3_hold");
      nl += int'(load);
    end
    check("s3_withheld", nl, 0);
    en = 1;
    nl = 0;
    repeat (4) begin
      tick("s3_go");
      nl += int'(load);
    end
    check("s3_single", nl, 1);
    // asynchronous reset in the middle of yellow
    wait_load("s6_g", 14);
    repeat (2) tick();
    #3;
    rst_n = 0;
    #1;
    check("s6_async", 32'(dut_out()), 32'(7'b0000100));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_load("s6_first", 1);
    wait_load("s6_g2y", 17);
    wait_load("s6_y2r", 5);
    // random run
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    flash_req = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if (flash_req ? $urandom_range(0, 29) == 0 : $urandom_range(0, 199) == 0) flash_req = ~flash_req;
      ovr = ($urandom_range(0, 19) == 0);
      ovr_val = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
      rst_n = ($urandom_range(0, 999) != 0);
      tick("rand");
    end
    ovr = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
